// File: rtl/game_sequencer_if.sv
// Game-sequencer side-band bus: the screen-clear handshake with the drawer
// and the run/re-centre controls plus the y feedback of the ball datapath.
interface game_sequencer_if;
    logic       clear_req;
    logic       clear_done;
    logic       ball_reset;
    logic       ball_run;
    logic [9:0] ball_y;

    // The sequencer drives requests and ball controls and observes feedback.
    modport master (
        output clear_req,
        output ball_reset,
        output ball_run,
        input  clear_done,
        input  ball_y
    );

    // The drawer/ball datapath side sees the mirror image.
    modport slave (
        input  clear_req,
        input  ball_reset,
        input  ball_run,
        output clear_done,
        output ball_y
    );
endinterface

// File: rtl/game_sequencer.sv
// Brick-breaker game-flow controller: start, screen clear, serve, play,
// life-lost pause, game over and win. Owns the life counter and detects the
// ball crossing below the paddle line. All outputs come straight from flops.
module game_sequencer #(
    parameter logic [9:0] PLAT_Y       = 10'd440,
    parameter logic [9:0] BALL_START_Y = 10'd300,
    parameter logic [7:0] PAUSE_FRAMES = 8'd60
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    launch,
    input  logic                    frame_tick,
    input  logic [7:0]              bricks_left,
    input  logic [9:0]              starting_lives,
    output logic [9:0]              lives,
    output logic [2:0]              state,
    output logic                    game_over,
    output logic                    game_won,
    game_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SERVE = 3'd2,
        ST_PLAY  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5,
        ST_WON   = 3'd6
    } state_e;

    state_e     state_r,      state_nxt_s;
    logic [9:0] lives_r,      lives_nxt_s;
    logic       clear_req_r,  clear_req_nxt_s;
    logic       ball_reset_r, ball_reset_nxt_s;
    logic       ball_run_r,   ball_run_nxt_s;
    logic       game_over_r,  game_over_nxt_s;
    logic       game_won_r,   game_won_nxt_s;
    logic [7:0] pause_cnt_r,  pause_cnt_nxt_s;
    logic [9:0] prev_y_r;
    logic       start_q_r;
    logic       launch_q_r;

    logic       start_edge_s;
    logic       launch_edge_s;
    logic       cross_s;

    // A zero life request would start a game that is already lost.
    function automatic logic [9:0] load_lives(input logic [9:0] req);
        return (req == 10'd0) ? 10'd1 : req;
    endfunction

    assign start_edge_s  = start  & ~start_q_r;
    assign launch_edge_s = launch & ~launch_q_r;
    assign cross_s       = (bus.ball_y > PLAT_Y) && (prev_y_r <= PLAT_Y);

    assign bus.clear_req  = clear_req_r;
    assign bus.ball_reset = ball_reset_r;
    assign bus.ball_run   = ball_run_r;
    assign lives          = lives_r;
    assign state          = state_r;
    assign game_over      = game_over_r;
    assign game_won       = game_won_r;

    // State, output and tracking registers; keys reset high so a held key gives no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            lives_r      <= 10'd0;
            clear_req_r  <= 1'b0;
            ball_reset_r <= 1'b0;
            ball_run_r   <= 1'b0;
            game_over_r  <= 1'b0;
            game_won_r   <= 1'b0;
            pause_cnt_r  <= 8'd0;
            prev_y_r     <= BALL_START_Y;
            start_q_r    <= 1'b1;
            launch_q_r   <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            lives_r      <= lives_nxt_s;
            clear_req_r  <= clear_req_nxt_s;
            ball_reset_r <= ball_reset_nxt_s;
            ball_run_r   <= ball_run_nxt_s;
            game_over_r  <= game_over_nxt_s;
            game_won_r   <= game_won_nxt_s;
            pause_cnt_r  <= pause_cnt_nxt_s;
            prev_y_r     <= ball_reset_nxt_s ? BALL_START_Y : bus.ball_y;
            start_q_r    <= start;
            launch_q_r   <= launch;
        end
    end

    // Next-state and next-output decode; everything holds unless a state acts.
    always_comb begin
        state_nxt_s      = state_r;
        lives_nxt_s      = lives_r;
        clear_req_nxt_s  = clear_req_r;
        ball_reset_nxt_s = 1'b0;
        ball_run_nxt_s   = ball_run_r;
        game_over_nxt_s  = game_over_r;
        game_won_nxt_s   = game_won_r;
        pause_cnt_nxt_s  = pause_cnt_r;

        case (state_r)
            ST_IDLE, ST_OVER, ST_WON: begin
                if (start_edge_s) begin
                    lives_nxt_s     = load_lives(starting_lives);
                    clear_req_nxt_s = 1'b1;
                    game_over_nxt_s = 1'b0;
                    game_won_nxt_s  = 1'b0;
                    state_nxt_s     = ST_CLEAR;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_CLEAR: begin
                if (bus.clear_done) begin
                    clear_req_nxt_s  = 1'b0;
                    ball_reset_nxt_s = 1'b1;
                    state_nxt_s      = ST_SERVE;
                end else begin
                    clear_req_nxt_s = 1'b1;
                end
            end
            ST_SERVE: begin
                if (launch_edge_s) begin
                    ball_run_nxt_s = 1'b1;
                    state_nxt_s    = ST_PLAY;
                end else begin
                    ball_run_nxt_s = 1'b0;
                end
            end
            ST_PLAY: begin
                // A cleared brick map wins even if the ball drops the same cycle.
                if (bricks_left == 8'd0) begin
                    ball_run_nxt_s = 1'b0;
                    game_won_nxt_s = 1'b1;
                    state_nxt_s    = ST_WON;
                end else if (cross_s && (lives_r <= 10'd1)) begin
                    lives_nxt_s     = 10'd0;
                    ball_run_nxt_s  = 1'b0;
                    game_over_nxt_s = 1'b1;
                    state_nxt_s     = ST_OVER;
                end else if (cross_s) begin
                    lives_nxt_s     = lives_r - 10'd1;
                    ball_run_nxt_s  = 1'b0;
                    pause_cnt_nxt_s = PAUSE_FRAMES;
                    state_nxt_s     = ST_PAUSE;
                end else begin
                    ball_run_nxt_s = 1'b1;
                end
            end
            ST_PAUSE: begin
                // Counter of 1 (or an unexpected 0) ends the pause on this tick.
                if (frame_tick && (pause_cnt_r <= 8'd1)) begin
                    pause_cnt_nxt_s  = 8'd0;
                    ball_reset_nxt_s = 1'b1;
                    state_nxt_s      = ST_SERVE;
                end else if (frame_tick) begin
                    pause_cnt_nxt_s = pause_cnt_r - 8'd1;
                end else begin
                    pause_cnt_nxt_s = pause_cnt_r;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                clear_req_nxt_s = 1'b0;
                ball_run_nxt_s  = 1'b0;
                game_over_nxt_s = 1'b0;
                game_won_nxt_s  = 1'b0;
                pause_cnt_nxt_s = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: walks the full game flow with
// hand-computed expectations checked by immediate assertions.
module tb_game_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       launch;
    logic       frame_tick;
    logic [7:0] bricks_left;
    logic [9:0] starting_lives;
    logic [9:0] lives;
    logic [2:0] state;
    logic       game_over;
    logic       game_won;

    int passed;
    int fails;
    int total;

    game_sequencer_if bus ();

    game_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .launch         (launch),
        .frame_tick     (frame_tick),
        .bricks_left    (bricks_left),
        .starting_lives (starting_lives),
        .lives          (lives),
        .state          (state),
        .game_over      (game_over),
        .game_won       (game_won),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cross();
        bus.ball_y = 10'd439;
        step();
        bus.ball_y = 10'd441;
        step();
    endtask

    task automatic do_launch();
        launch = 1'b1;
        step();
        launch = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear_done = 1'b1;
        step();
        bus.clear_done = 1'b0;
        step();
    endtask

    initial begin
        passed = 0;
        fails  = 0;
        total  = 0;
        reset          = 1'b1;
        start          = 1'b1;
        launch         = 1'b0;
        frame_tick     = 1'b0;
        bricks_left    = 8'd10;
        starting_lives = 10'd3;
        bus.clear_done = 1'b0;
        bus.ball_y     = 10'd300;
        #2;
        check("rst_state",      state, 3'd0);
        check("rst_lives",      lives, 10'd0);
        check("rst_clear_req",  bus.clear_req, 1'b0);
        check("rst_ball_reset", bus.ball_reset, 1'b0);
        check("rst_ball_run",   bus.ball_run, 1'b0);
        check("rst_game_over",  game_over, 1'b0);
        check("rst_game_won",   game_won, 1'b0);

        // Release reset with start still held: no edge may be seen.
        step();
        reset = 1'b0;
        step();
        step();
        step();
        check("held_start_idle", state, 3'd0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state_clear", state, 3'd1);
        check("start_clear_req",   bus.clear_req, 1'b1);
        check("start_lives",       lives, 10'd3);

        // Drawer finishes five cycles later.
        repeat (4) step();
        check("clear_wait_state", state, 3'd1);
        check("clear_wait_req",   bus.clear_req, 1'b1);
        bus.clear_done = 1'b1;
        step();
        bus.clear_done = 1'b0;
        check("clr_done_state",      state, 3'd2);
        check("clr_done_req",        bus.clear_req, 1'b0);
        check("clr_done_ball_reset", bus.ball_reset, 1'b1);
        check("clr_done_ball_run",   bus.ball_run, 1'b0);
        step();
        check("serve_ball_reset_1cy", bus.ball_reset, 1'b0);
        check("serve_hold_state",     state, 3'd2);

        // Start is ignored while serving.
        start = 1'b1;
        step();
        start = 1'b0;
        check("serve_ignores_start", state, 3'd2);

        do_launch();
        check("launch_state",    state, 3'd3);
        check("launch_ball_run", bus.ball_run, 1'b1);

        // First life lost.
        do_cross();
        check("cross1_lives",    lives, 10'd2);
        check("cross1_state",    state, 3'd4);
        check("cross1_ball_run", bus.ball_run, 1'b0);
        step();
        step();
        check("pause_hold_lives", lives, 10'd2);

        // 59 ticks keep the pause, the 60th ends it.
        frame_tick = 1'b1;
        repeat (59) step();
        frame_tick = 1'b0;
        step();
        check("pause59_state",      state, 3'd4);
        check("pause59_ball_reset", bus.ball_reset, 1'b0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("pause60_state",      state, 3'd2);
        check("pause60_ball_reset", bus.ball_reset, 1'b1);
        step();
        check("pause60_reset_1cy",  bus.ball_reset, 1'b0);
        // Frame ticks outside PAUSE change nothing.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("serve_ignores_tick", state, 3'd2);

        // Ball still parked below the line: no further life lost.
        do_launch();
        step();
        step();
        check("held_441_lives", lives, 10'd2);
        check("held_441_state", state, 3'd3);

        // Second life lost, then serve again.
        do_cross();
        check("cross2_lives", lives, 10'd1);
        frame_tick = 1'b1;
        repeat (60) step();
        frame_tick = 1'b0;
        check("pause2_done_state", state, 3'd2);
        do_launch();

        // Last life lost.
        do_cross();
        check("over_state",     state, 3'd5);
        check("over_lives",     lives, 10'd0);
        check("over_flag",      game_over, 1'b1);
        check("over_ball_run",  bus.ball_run, 1'b0);
        step();
        check("over_hold_flag", game_over, 1'b1);

        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_state",     state, 3'd1);
        check("restart_lives",     lives, 10'd3);
        check("restart_game_over", game_over, 1'b0);

        // Win beats a simultaneous cross.
        do_clear();
        do_launch();
        bus.ball_y = 10'd439;
        step();
        bus.ball_y  = 10'd441;
        bricks_left = 8'd0;
        step();
        check("win_state",    state, 3'd6);
        check("win_flag",     game_won, 1'b1);
        check("win_lives",    lives, 10'd3);
        check("win_ball_run", bus.ball_run, 1'b0);
        step();
        check("win_hold", game_won, 1'b1);

        // Zero starting lives loads as one.
        starting_lives = 10'd0;
        bricks_left    = 8'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_lives_load",  lives, 10'd1);
        check("zero_lives_state", state, 3'd1);
        check("zero_lives_won",   game_won, 1'b0);

        // Fresh game into PAUSE, then reset mid-pause.
        reset = 1'b1;
        step();
        reset = 1'b0;
        starting_lives = 10'd3;
        bus.ball_y     = 10'd300;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        do_clear();
        do_launch();
        do_cross();
        check("pause3_state", state, 3'd4);
        frame_tick = 1'b1;
        repeat (30) step();
        frame_tick = 1'b0;
        check("pause3_mid_state", state, 3'd4);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state",     state, 3'd0);
        check("async_rst_lives",     lives, 10'd0);
        check("async_rst_ball_run",  bus.ball_run, 1'b0);
        check("async_rst_clear_req", bus.clear_req, 1'b0);
        check("async_rst_ball_rst",  bus.ball_reset, 1'b0);
        check("async_rst_over",      game_over, 1'b0);
        check("async_rst_won",       game_won, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the brick breaker.
- Sequences the game through start, screen clear, serve, play, life-lost pause, game over and win.
- Owns the life counter and detects when the ball crosses the paddle line (ball lost).
- Gates the ball datapath with a run enable and a one-cycle re-centre pulse, and handshakes with the screen-clear drawer.

Parameters:
- PLAT_Y, 10'd440: paddle line y. The ball is lost when it crosses below this line.
- BALL_START_Y, 10'd300: ball y after re-centre. Also the reset/reload value of the previous-y register.
- PAUSE_FRAMES, 8'd60: frames to wait after a life is lost. Must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  start key, level; rising edge detected internally
- launch  in  1  serve key, level; rising edge detected internally
- frame_tick  in  1  one-cycle pulse per video frame
- ball_y  in  10  current ball y from the ball datapath
- bricks_left  in  8  remaining bricks from the brick map
- starting_lives  in  10  life count, sampled on a start edge
- clear_done  in  1  drawer has finished clearing the screen
- clear_req  out  1  request a screen clear; held until acknowledged
- ball_reset  out  1  one-cycle pulse: re-centre ball and paddle
- ball_run  out  1  ball datapath may move
- lives  out  10  remaining lives
- state  out  3  current state encoding
- game_over  out  1  high in OVER
- game_won  out  1  high in WON

Behaviour:
- State encoding: IDLE=0, CLEAR=1, SERVE=2, PLAY=3, PAUSE=4, OVER=5, WON=6. Codes 7 and above are illegal and return to IDLE on the next cycle.
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-game):
  - state=IDLE; lives=0; clear_req=0; ball_reset=0; ball_run=0; game_over=0; game_won=0; pause counter=0.
  - prev_y=BALL_START_Y.
  - start_q=1 and launch_q=1, so a key already held during reset produces no edge.
- Edge detection: start_edge = start & ~start_q; launch_edge = launch & ~launch_q. Both delay registers update every cycle.
- prev_y <= ball_y every cycle. The exception is the cycle that asserts ball_reset, when prev_y <= BALL_START_Y.
- cross = (ball_y > PLAT_Y) & (prev_y <= PLAT_Y), unsigned 10-bit compare.
- IDLE, OVER, WON: on start_edge:
  - lives <= starting_lives, except a value of 0 loads as 1.
  - clear_req <= 1; game_over and game_won <= 0; go to CLEAR.
  - OVER holds game_over=1 and WON holds game_won=1 until that edge.
- CLEAR:
  - clear_req stays high until a cycle samples clear_done=1.
  - The next cycle: clear_req=0, ball_reset=1 for exactly one cycle, state=SERVE.
  - clear_done while not in CLEAR is ignored.
- SERVE: ball_run=0. On launch_edge: ball_run <= 1, state=PLAY. start is ignored.
- PLAY, priority order:
  - (1) bricks_left==0 → WON, ball_run=0. A win beats a simultaneous cross.
  - (2) cross with lives==1 → lives=0, ball_run=0, OVER.
  - (3) cross with lives>1 → lives decrements by 1, ball_run=0, pause counter=PAUSE_FRAMES, PAUSE.
  - A cross is counted only in PLAY; ball_y movement in other states never costs a life.
- PAUSE:
  - Each frame_tick decrements the counter.
  - A frame_tick with counter==1 → ball_reset=1 for one cycle, counter=0, SERVE.
  - frame_tick is ignored in all other states.
- lives never underflows; it changes only on a start-edge load and on a PLAY cross.
- Latency: every transition occurs on the clock edge after the triggering input is sampled.

Test Plan:
- Reset with start held high, then release and press again: no transition while held; the fresh edge gives state=CLEAR, clear_req=1, lives=3 (starting_lives=3).
- In CLEAR, assert clear_done 5 cycles later: clear_req falls, ball_reset high for exactly 1 cycle, state=SERVE, ball_run=0. A launch edge then gives state=PLAY, ball_run=1.
- PLAY with lives=3, ball_y stepping 439→441: lives=2, state=PAUSE. After 60 frame_ticks: one ball_reset pulse, state=SERVE. ball_y held at 441 causes no further decrement.
- PLAY with lives=1 and a cross: lives=0, state=OVER, game_over=1. A start edge then reloads lives=3 and gives state=CLEAR, game_over=0.
- PLAY with bricks_left falling to 0 in the same cycle as a cross: state=WON, game_won=1, lives unchanged. Separately, starting_lives=0 on start loads lives=1.
- Assert reset mid-PAUSE (counter=30): all outputs return to reset values immediately, without waiting for a clock edge.
